// File: rtl/disp_pkg.sv
// Shared view encoding and request-priority helpers for the display scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   VIEW_* constants   2-bit view codes that drive the display mux chain
//   state_t            scheduler FSM states; each state's code equals its view code
//   prio_view()        3-bit pending vector {global, pbest, score} -> highest-priority view
//   view_bit()         view code -> its bit in the pending vector (0 for the game view)
package disp_pkg;

    localparam logic [1:0] VIEW_GAME   = 2'd0;
    localparam logic [1:0] VIEW_SCORE  = 2'd1;
    localparam logic [1:0] VIEW_PBEST  = 2'd2;
    localparam logic [1:0] VIEW_GLOBAL = 2'd3;

    // State codes equal view codes, so the select output is a straight copy
    // and a numerically larger code is also the higher-priority view.
    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_SCORE   = 2'd1,
        ST_PBEST   = 2'd2,
        ST_GLOBAL  = 2'd3
    } state_t;

    // Fixed priority: global > pbest > score. Returns VIEW_GAME when nothing is pending.
    function automatic logic [1:0] prio_view(input logic [2:0] pend);
        logic [1:0] v;
        v = VIEW_GAME;
        if (pend[2])      v = VIEW_GLOBAL;
        else if (pend[1]) v = VIEW_PBEST;
        else if (pend[0]) v = VIEW_SCORE;
        return v;
    endfunction

    function automatic logic [2:0] view_bit(input logic [1:0] v);
        logic [2:0] b;
        case (v)
            VIEW_SCORE:  b = 3'b001;
            VIEW_PBEST:  b = 3'b010;
            VIEW_GLOBAL: b = 3'b100;
            default:     b = 3'b000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
// Latency: load/decrement take effect on the next clk edge; o_zero is combinational from the count.
// Backpressure: none; i_load has priority over i_en.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (count -> 0)
//   i_load        load i_load_val on the next edge
//   i_load_val    value to load
//   i_en          decrement by one on the next edge (ignored when count is 0)
//   o_zero        count is zero
module hold_counter #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the shared 7-segment bank / LED array between game, score, personal-best and global views.
// Latency: request pulse -> pending bit next edge -> view change (disp_sel, grant) the edge after (2 cycles).
// Backpressure: requests never stall; they wait in pending until the current hold ends (or preempt, if enabled).
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   logged_in            session active; low forces the game view and flushes pending requests
//   req_score/pbest/global  one-cycle request pulses
//   dismiss              one-cycle pulse ending the current hold early
//   disp_sel             0 game/timer, 1 score, 2 personal best, 3 global (registered)
//   score_display        disp_sel == 1 (registered)
//   GlobalScore_display  disp_sel == 2 or 3 (registered)
//   grant                one-cycle pulse on every entry into a non-default view
//   pending              latched requests {global, pbest, score}
//
// Build option: define DISP_SCHED_PREEMPT_EN to let a strictly higher-priority
// pending request cut the current hold short.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       logged_in,
    input  logic       req_score,
    input  logic       req_pbest,
    input  logic       req_global,
    input  logic       dismiss,
    output logic [1:0] disp_sel,
    output logic       score_display,
    output logic       GlobalScore_display,
    output logic       grant,
    output logic [2:0] pending
);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_pending;
    logic [2:0]       w_pending_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic [1:0]       r_disp_sel;
    logic             r_score_display;
    logic             r_global_display;

    logic [2:0]       w_req;
    logic [1:0]       w_cur_view;
    logic [2:0]       w_cur_bit;
    logic             w_rereq;
    logic [1:0]       w_top;
    logic             w_preempt;
    logic             w_enter;
    logic [2:0]       w_set;
    logic [2:0]       w_clr;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_en;
    logic             w_cnt_zero;

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    assign w_req      = {req_global, req_pbest, req_score};
    assign w_cur_view = r_state;
    assign w_cur_bit  = view_bit(w_cur_view);
    // A request for the view already on screen only extends the hold.
    assign w_rereq    = |(w_req & w_cur_bit);
    assign w_top      = prio_view(r_pending);

`ifdef DISP_SCHED_PREEMPT_EN
    assign w_preempt  = (r_state != ST_DEFAULT) && (w_top > w_cur_view);
`else
    assign w_preempt  = 1'b0;
`endif

    // Next-state, pending and hold-counter control.
    // Within a hold the order of precedence is: logout, preempt, dismiss/expiry,
    // re-request reload, plain decrement. A re-request arriving on the expiry
    // cycle counts as a reload, so the view stays up.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = 1'b0;
        w_enter        = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = HOLD_RELOAD;
        w_cnt_en       = 1'b0;
        w_set          = w_req & ~w_cur_bit;
        w_clr          = 3'b000;

        if (!logged_in) begin
            w_state_nxt    = ST_DEFAULT;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = '0;
            w_set          = 3'b000;
            w_clr          = 3'b111;
        end else if (r_state == ST_DEFAULT) begin
            if (r_pending != 3'b000) begin
                w_enter = 1'b1;
            end
        end else if (w_preempt) begin
            w_enter = 1'b1;
        end else if (dismiss || (w_cnt_zero && !w_rereq)) begin
            if (r_pending != 3'b000) begin
                // Chain straight into the next view; no game-view gap.
                w_enter = 1'b1;
            end else begin
                w_state_nxt    = ST_DEFAULT;
                w_cnt_load     = 1'b1;
                w_cnt_load_val = '0;
            end
        end else if (w_rereq) begin
            w_cnt_load = 1'b1;
        end else begin
            w_cnt_en = 1'b1;
        end

        if (w_enter) begin
            w_state_nxt    = state_t'(w_top);
            w_grant_nxt    = 1'b1;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = HOLD_RELOAD;
            w_clr          = view_bit(w_top);
        end

        // Clear first, then set: a new request for the view being entered stays latched.
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_DEFAULT;
            r_pending        <= 3'b000;
            r_grant          <= 1'b0;
            r_disp_sel       <= VIEW_GAME;
            r_score_display  <= 1'b0;
            r_global_display <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_pending        <= w_pending_nxt;
            r_grant          <= w_grant_nxt;
            r_disp_sel       <= w_state_nxt;
            r_score_display  <= (w_state_nxt == ST_SCORE);
            r_global_display <= (w_state_nxt == ST_PBEST) || (w_state_nxt == ST_GLOBAL);
        end
    end

    assign disp_sel            = r_disp_sel;
    assign score_display       = r_score_display;
    assign GlobalScore_display = r_global_display;
    assign grant               = r_grant;
    assign pending             = r_pending;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

    localparam int HOLD = 4;
`ifdef DISP_SCHED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       logged_in = 1'b0;
    logic       req_score = 1'b0;
    logic       req_pbest = 1'b0;
    logic       req_global = 1'b0;
    logic       dismiss = 1'b0;
    logic [1:0] disp_sel;
    logic       score_display;
    logic       GlobalScore_display;
    logic       grant;
    logic [2:0] pending;

    int errors = 0;
    int checks = 0;

    // Reference model: current view (0..3), cycles already spent in it beyond
    // the first, latched requests and the grant pulse for this cycle.
    int     m_view;
    int     m_elapsed;
    bit [2:0] m_pend;
    bit     m_grant;

    display_scheduler #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (25)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .logged_in           (logged_in),
        .req_score           (req_score),
        .req_pbest           (req_pbest),
        .req_global          (req_global),
        .dismiss             (dismiss),
        .disp_sel            (disp_sel),
        .score_display       (score_display),
        .GlobalScore_display (GlobalScore_display),
        .grant               (grant),
        .pending             (pending)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_view = 0; m_elapsed = 0; m_pend = 3'b000; m_grant = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit p, input bit g, input bit d, input bit li);
        bit [2:0] req;
        bit [2:0] setmask;
        int top;
        int nxt;
        bit rereq;
        req = {g, p, s};
        m_grant = 1'b0;
        if (!li) begin
            m_view = 0; m_elapsed = 0; m_pend = 3'b000;
            return;
        end
        top = 0;
        for (int v = 3; v >= 1; v--) if (m_pend[v-1] && top == 0) top = v;
        rereq = (m_view != 0) && req[m_view-1];
        setmask = req;
        if (rereq) setmask[m_view-1] = 1'b0;
        nxt = 0;
        if (m_view == 0) begin
            nxt = top;
        end else if (PREEMPT && top > m_view) begin
            nxt = top;
        end else if (d || (m_elapsed >= HOLD - 1 && !rereq)) begin
            if (top != 0) nxt = top;
            else begin m_view = 0; m_elapsed = 0; end
        end else if (rereq) begin
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        if (nxt != 0) begin
            m_view = nxt; m_elapsed = 0; m_grant = 1'b1; m_pend[nxt-1] = 1'b0;
        end
        m_pend = m_pend | setmask;
    endfunction

    // One clock cycle with the given inputs held across its rising edge.
    task automatic tick(input bit s, input bit p, input bit g, input bit d, input bit li);
        @(negedge clk);
        req_score = s; req_pbest = p; req_global = g; dismiss = d; logged_in = li;
        @(posedge clk);
        model_step(s, p, g, d, li);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; logged_in = 1'b1;
        req_score = 1'b0; req_pbest = 1'b0; req_global = 1'b0; dismiss = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({disp_sel, score_display, GlobalScore_display, grant, pending} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d sd=%0b gd=%0b gr=%0b pend=%b want all 0",
                     disp_sel, score_display, GlobalScore_display, grant, pending);
        end
    endtask

    task automatic test_single_score();
        apply_reset();
        tick(1, 0, 0, 0, 1);                       // cycle 1
        checks++;
        if (pending !== 3'b001 || disp_sel !== 2'd0) begin
            errors++; $display("FAIL single_c1: got pend=%b sel=%0d want 001/0", pending, disp_sel);
        end
        tick(0, 0, 0, 0, 1);                       // cycle 2
        checks++;
        if (disp_sel !== 2'd1 || grant !== 1'b1 || pending !== 3'b000) begin
            errors++; $display("FAIL single_c2: got sel=%0d gr=%0b pend=%b want 1/1/000", disp_sel, grant, pending);
        end
        for (int c = 3; c <= 5; c++) begin
            tick(0, 0, 0, 0, 1);
            checks++;
            if (score_display !== 1'b1 || grant !== 1'b0) begin
                errors++; $display("FAIL single_hold c%0d: got sd=%0b gr=%0b want 1/0", c, score_display, grant);
            end
        end
        tick(0, 0, 0, 0, 1);                       // cycle 6
        checks++;
        if (disp_sel !== 2'd0 || score_display !== 1'b0) begin
            errors++; $display("FAIL single_c6: got sel=%0d sd=%0b want 0/0", disp_sel, score_display);
        end
    endtask

    task automatic test_multi_request();
        int grants;
        apply_reset();
        grants = 0;
        tick(1, 0, 1, 0, 1);                       // cycle 1
        checks++;
        if (pending !== 3'b101) begin
            errors++; $display("FAIL multi_latch: got pend=%b want 101", pending);
        end
        for (int c = 2; c <= 5; c++) begin
            tick(0, 0, 0, 0, 1);
            grants += grant;
            checks++;
            if (disp_sel !== 2'd3 || pending !== 3'b001 || GlobalScore_display !== 1'b1) begin
                errors++; $display("FAIL multi_global c%0d: got sel=%0d pend=%b gd=%0b want 3/001/1",
                                   c, disp_sel, pending, GlobalScore_display);
            end
        end
        for (int c = 6; c <= 9; c++) begin
            tick(0, 0, 0, 0, 1);
            grants += grant;
            checks++;
            if (disp_sel !== 2'd1 || pending !== 3'b000) begin
                errors++; $display("FAIL multi_score c%0d: got sel=%0d pend=%b want 1/000", c, disp_sel, pending);
            end
        end
        tick(0, 0, 0, 0, 1);                       // cycle 10
        grants += grant;
        checks++;
        if (disp_sel !== 2'd0 || grants != 2) begin
            errors++; $display("FAIL multi_end: got sel=%0d grants=%0d want 0/2", disp_sel, grants);
        end
    endtask

    task automatic test_rerequest();
        apply_reset();
        tick(1, 0, 0, 0, 1);                       // cycle 1
        repeat (3) tick(0, 0, 0, 0, 1);            // cycles 2..4, counter reaches 1
        tick(1, 0, 0, 0, 1);                       // cycle 5: reloaded
        checks++;
        if (pending !== 3'b000 || grant !== 1'b0) begin
            errors++; $display("FAIL rereq_pend: got pend=%b gr=%0b want 000/0", pending, grant);
        end
        for (int c = 6; c <= 8; c++) begin
            tick(0, 0, 0, 0, 1);
            checks++;
            if (disp_sel !== 2'd1) begin
                errors++; $display("FAIL rereq_hold c%0d: got sel=%0d want 1", c, disp_sel);
            end
        end
        tick(0, 0, 0, 0, 1);                       // cycle 9
        checks++;
        if (disp_sel !== 2'd0) begin
            errors++; $display("FAIL rereq_end: got sel=%0d want 0", disp_sel);
        end
    endtask

    task automatic test_dismiss();
        apply_reset();
        tick(0, 0, 0, 1, 1);                       // dismiss in game view: no effect
        checks++;
        if (disp_sel !== 2'd0 || pending !== 3'b000 || grant !== 1'b0) begin
            errors++; $display("FAIL dismiss_default: got sel=%0d pend=%b gr=%0b want 0/000/0", disp_sel, pending, grant);
        end
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        checks++;
        if (disp_sel !== 2'd2 || GlobalScore_display !== 1'b1) begin
            errors++; $display("FAIL dismiss_pbest: got sel=%0d gd=%0b want 2/1", disp_sel, GlobalScore_display);
        end
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 1);
        checks++;
        if (disp_sel !== 2'd0 || GlobalScore_display !== 1'b0) begin
            errors++; $display("FAIL dismiss_exit: got sel=%0d gd=%0b want 0/0", disp_sel, GlobalScore_display);
        end
    endtask

    task automatic test_logout();
        apply_reset();
        tick(1, 0, 1, 0, 1);
        tick(0, 0, 0, 0, 1);                       // GLOBAL with score pending
        checks++;
        if (disp_sel !== 2'd3 || pending !== 3'b001) begin
            errors++; $display("FAIL logout_setup: got sel=%0d pend=%b want 3/001", disp_sel, pending);
        end
        tick(0, 1, 0, 0, 0);
        checks++;
        if (disp_sel !== 2'd0 || pending !== 3'b000 || grant !== 1'b0 || GlobalScore_display !== 1'b0) begin
            errors++; $display("FAIL logout_exit: got sel=%0d pend=%b gr=%0b gd=%0b want 0/000/0/0",
                               disp_sel, pending, grant, GlobalScore_display);
        end
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        checks++;
        if (disp_sel !== 2'd0 || pending !== 3'b000 || grant !== 1'b0) begin
            errors++; $display("FAIL logout_drop: got sel=%0d pend=%b gr=%0b want 0/000/0", disp_sel, pending, grant);
        end
    endtask

    task automatic test_reset_midhold();
        apply_reset();
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);                       // SCORE, grant high
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (disp_sel !== 2'd0 || score_display !== 1'b0 || grant !== 1'b0) begin
            errors++; $display("FAIL reset_midhold: got sel=%0d sd=%0b gr=%0b want 0/0/0", disp_sel, score_display, grant);
        end
        apply_reset();
    endtask

    task automatic test_preempt();
        logic [1:0] want_c4;
        logic       want_g4;
        apply_reset();
        want_c4 = PREEMPT ? 2'd3 : 2'd1;
        want_g4 = PREEMPT;
        tick(1, 0, 0, 0, 1);                       // cycle 1
        tick(0, 0, 0, 0, 1);                       // cycle 2: SCORE
        tick(0, 0, 1, 0, 1);                       // cycle 3: global pending
        checks++;
        if (disp_sel !== 2'd1 || pending !== 3'b100) begin
            errors++; $display("FAIL preempt_c3: got sel=%0d pend=%b want 1/100", disp_sel, pending);
        end
        tick(0, 0, 0, 0, 1);                       // cycle 4
        checks++;
        if (disp_sel !== want_c4 || grant !== want_g4) begin
            errors++; $display("FAIL preempt_c4: got sel=%0d gr=%0b want %0d/%0b", disp_sel, grant, want_c4, want_g4);
        end
        if (!PREEMPT) begin
            tick(0, 0, 0, 0, 1);                   // cycle 5: still SCORE
            tick(0, 0, 0, 0, 1);                   // cycle 6: GLOBAL
            checks++;
            if (disp_sel !== 2'd3 || grant !== 1'b1) begin
                errors++; $display("FAIL preempt_wait_c6: got sel=%0d gr=%0b want 3/1", disp_sel, grant);
            end
        end
    endtask

    task automatic test_random();
        bit s, p, g, d, li;
        logic [7:0] got;
        logic [7:0] want;
        int bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            s  = ($urandom_range(0, 5) == 0);
            p  = ($urandom_range(0, 5) == 0);
            g  = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 11) == 0);
            li = ($urandom_range(0, 39) != 0);
            tick(s, p, g, d, li);
            got  = {disp_sel, score_display, GlobalScore_display, grant, pending};
            want = {2'(m_view), (m_view == 1), (m_view >= 2), m_grant, m_pend};
            checks++;
            if (got !== want) begin
                errors++;
                if (bad < 10) $display("FAIL random c%0d: got sel/sd/gd/gr/pend=%b want %b", c, got, want);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_score();
        test_multi_request();
        test_rerequest();
        test_dismiss();
        test_logout();
        test_reset_midhold();
        test_preempt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the shared six-digit 7-segment bank and the LED array between four display owners:
  - game/timer view (default owner)
  - current score
  - personal best
  - global winner
- Replaces the ad-hoc select lines into the display mux tree with one arbitrated, time-held select.
- Sits between GameController/Score_Tracking (requesters) and the Mymux selection chain (consumer).

Parameters:
- HOLD_CYCLES, 25000000, clk cycles a granted non-default view stays on the display (0.5 s at 50 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 25, width of the hold counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- logged_in  input  1  session active; low forces the default view
- req_score  input  1  one-cycle pulse: show current score
- req_pbest  input  1  one-cycle pulse: show personal best
- req_global  input  1  one-cycle pulse: show global winner
- dismiss  input  1  one-cycle pulse (shaped MP button): end the current hold early
- disp_sel  output  2  0 = game/timer, 1 = score, 2 = personal best, 3 = global
- score_display  output  1  high when disp_sel==1
- GlobalScore_display  output  1  high when disp_sel==2 or 3
- grant  output  1  one-cycle pulse on every entry into a non-default view
- pending  output  3  latched requests {global, pbest, score}

Behaviour:
- Reset: all outputs 0, state DEFAULT, hold counter 0. Reset mid-hold aborts immediately.
- States:
  - DEFAULT (sel 0)
  - SCORE (sel 1)
  - PBEST (sel 2)
  - GLOBAL (sel 3)
- disp_sel, score_display and GlobalScore_display are registered and decode directly from state.
- Request latching:
  - A request pulse sets its pending bit on the next edge.
  - If a set and a clear of the same bit coincide, the set wins.
- Re-request of the view currently shown:
  - Reloads the hold counter to HOLD_CYCLES-1.
  - Does not set its pending bit.
- Priority: global > pbest > score. Fixed priority, no fairness counter.
- DEFAULT with pending != 0 and logged_in=1:
  - Next edge enters the highest-priority pending view and clears that pending bit.
  - Loads counter to HOLD_CYCLES-1 and asserts grant for that one cycle.
  - Latency from request pulse to disp_sel change is 2 cycles.
- Non-default state: counter decrements each cycle. When counter==0 or dismiss=1:
  - pending != 0: go directly to the highest pending view (reload, grant, clear bit). No intervening DEFAULT cycle.
  - else: go to DEFAULT.
- Each view is therefore held for exactly HOLD_CYCLES cycles unless dismissed.
- Non-preemptive: a higher-priority request during a hold waits in pending.
- logged_in=0 (sampled at an edge):
  - Next state DEFAULT.
  - pending cleared; requests in that same cycle are dropped.
  - No grant.
- dismiss in DEFAULT: no effect.
- Simultaneous multiple request pulses: all latched; served in priority order.
- Hold counter never underflows; it is held at 0 in DEFAULT.

Optional Feature:
- DISP_SCHED_PREEMPT_EN
- Defined: in a non-default state, a pending request of strictly higher priority than the current view ends the hold on the next edge and switches to it (reload, grant, clear bit). Equal or lower priority still waits.
- Undefined: strictly non-preemptive as described in Behaviour.

Decomposition:
- Shared package disp_pkg:
  - 2-bit view encoding constants VIEW_GAME=0, VIEW_SCORE=1, VIEW_PBEST=2, VIEW_GLOBAL=3
  - priority-encode function (3-bit pending -> view code)
- Sub-module hold_counter: loadable down-counter with load, enable and zero flag. Parameterised by CNT_W; reusable by HalfsecTimer-style blocks.
- FSM and pending register stay in display_scheduler.

Test Plan (HOLD_CYCLES=4):
- Reset, logged_in=1, req_score pulse at cycle 0 -> disp_sel=1 and grant=1 at cycle 2; score_display high cycles 2-5; disp_sel=0 at cycle 6.
- req_score and req_global pulsed in the same cycle:
  - GLOBAL shown for 4 cycles, then SCORE immediately (grant pulses twice), then DEFAULT.
  - pending reads 3'b001 during the global hold.
- In SCORE at counter=1, req_score pulse -> hold reloaded, SCORE lasts 4 more cycles; pending stays 0.
- In PBEST, dismiss pulse with nothing pending -> disp_sel=0 on next edge; GlobalScore_display falls the same edge.
- In GLOBAL with score pending, drop logged_in -> DEFAULT next edge, pending=0, no grant; req_pbest pulses while logged_in=0 are ignored.
- With DISP_SCHED_PREEMPT_EN: in SCORE, req_global -> GLOBAL at request+2 cycles with grant. Without the macro: GLOBAL starts only after SCORE's 4-cycle hold ends.
